// File: rtl/seg_scan.sv
// Time-multiplexed common-anode seven-segment driver with per-slot dead time.
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking.
module seg_scan #(
  parameter int DIGITS = 4,
  parameter int DIV    = 1024,
  parameter int DEAD   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int CW = $clog2(DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] sh_data;
  logic [DIGITS-1:0]   sh_dp;
  logic                dead;
  logic                hide;
  logic [3:0]          nib;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h18;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // With no dead time the comparison would be constant, so it is left out entirely.
  generate
    if (DEAD == 0) begin : g_no_dead
      assign dead = 1'b0;
    end else begin : g_dead
      assign dead = (cnt < CW'(DEAD));
    end
  endgenerate

  assign nib = sh_data[4*idx +: 4];

`ifdef SEG_SCAN_LZB_EN
  logic [DIGITS-1:0] suppress;

  // Walk down from the top digit; a digit stays blank until something non-zero is seen.
  always_comb begin
    logic seen;
    seen     = 1'b0;
    suppress = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen        = seen | (|sh_data[4*i +: 4]) | sh_dp[i];
      suppress[i] = ~seen & (i != 0);
    end
  end

  assign hide = suppress[idx];
`else
  assign hide = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= '0;
      sh_data <= '0;
      sh_dp   <= '0;
      an      <= '1;
      seg     <= 7'h7F;
      dp_n    <= 1'b1;
      frame   <= 1'b0;
    end else begin
      if (load) begin
        sh_data <= data;
        sh_dp   <= dp;
      end
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      frame <= (cnt == CNT_LAST) && (idx == IDX_LAST);
      // Outputs reflect the pre-edge slot position, hence the one-cycle lag.
      if (dead || hide) begin
        an   <= '1;
        seg  <= 7'h7F;
        dp_n <= 1'b1;
      end else begin
        an   <= ~(DIGITS'(1) << idx);
        seg  <= glyph(nib);
        dp_n <= ~sh_dp[idx];
      end
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan: a 4-digit and a 1-digit instance checked
// against a time-indexed reference model (tracks SEG_SCAN_LZB_EN when defined).
module tb_seg_scan;

  localparam int DIV  = 8;
  localparam int DEAD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        load, load1;
  logic [15:0] data;
  logic [3:0]  dp;
  logic [3:0]  data1;
  logic [0:0]  dp1;
  logic [6:0]  seg, seg1;
  logic        dp_n, dp_n1, frame, frame1;
  logic [3:0]  an;
  logic [0:0]  an1;

  int checks = 0;
  int passed = 0;

  // Model state: n counts edges since reset release, plus the expected shadow contents.
  int          n;
  logic [15:0] m_data;
  logic [3:0]  m_dp;
  logic [3:0]  m_data1;
  logic        m_dp1;
  logic [12:0] exp4;
  logic [9:0]  exp1;

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  seg_scan #(.DIGITS(4), .DIV(DIV), .DEAD(DEAD)) dut4 (
    .clk(clk), .rst(rst), .data(data), .dp(dp), .load(load),
    .seg(seg), .dp_n(dp_n), .an(an), .frame(frame)
  );

  seg_scan #(.DIGITS(1), .DIV(DIV), .DEAD(DEAD)) dut1 (
    .clk(clk), .rst(rst), .data(data1), .dp(dp1), .load(load1),
    .seg(seg1), .dp_n(dp_n1), .an(an1), .frame(frame1)
  );

  // Output word {an,seg,dp_n,frame} after the edge with index n, from the scan rules.
  function automatic logic [12:0] model(int digits, int t, logic [15:0] d, logic [3:0] p);
    int         c   = t % DIV;
    int         dig = (t / DIV) % digits;
    logic [3:0] a   = 4'hF;
    logic [6:0] s   = 7'h7F;
    logic       dn  = 1'b1;
    logic       f;
    bit         lit = (c >= DEAD);
`ifdef SEG_SCAN_LZB_EN
    if (dig != 0 && (d >> (4*dig)) == 16'h0 && (p >> dig) == 4'h0) lit = 1'b0;
`endif
    if (lit) begin
      a  = ~(4'b0001 << dig);
      s  = glyph_tab[d[4*dig +: 4]];
      dn = ~p[dig];
    end
    f = (c == DIV - 1) && (dig == digits - 1);
    return {a, s, dn, f};
  endfunction

  task automatic model_reset();
    n       = 0;
    m_data  = '0;
    m_dp    = '0;
    m_data1 = '0;
    m_dp1   = 1'b0;
  endtask

  task automatic tick(input logic ld, input logic [15:0] d, input logic [3:0] p,
                      input logic ld1, input logic [3:0] d1, input logic p1);
    logic [12:0] r1;
    load = ld; data = d; dp = p; load1 = ld1; data1 = d1; dp1 = p1;
    @(posedge clk);
    exp4 = model(4, n, m_data, m_dp);
    r1   = model(1, n, {12'h0, m_data1}, {3'b0, m_dp1});
    exp1 = r1[9:0];
    n++;
    if (ld)  begin m_data = d;   m_dp = p;   end
    if (ld1) begin m_data1 = d1; m_dp1 = p1; end
    #1;
    load = 1'b0; load1 = 1'b0;
  endtask

  task automatic idle();
    tick(1'b0, 16'h0, 4'h0, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; load1 = 1'b0; data = '0; dp = '0; data1 = '0; dp1 = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({an, seg, dp_n, frame} !== {4'hF, 7'h7F, 1'b1, 1'b0})
        $display("[TB] FAIL reset4 cyc=%0d: got an=%h seg=%h dp_n=%b frame=%b, want an=f seg=7f dp_n=1 frame=0",
                 i, an, seg, dp_n, frame);
      else passed++;
      checks++;
      if ({an1, seg1, dp_n1, frame1} !== {1'b1, 7'h7F, 1'b1, 1'b0})
        $display("[TB] FAIL reset1 cyc=%0d: got an=%h seg=%h dp_n=%b frame=%b, want an=1 seg=7f", i, an1, seg1, dp_n1, frame1);
      else passed++;
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++;
      if ({an, seg, dp_n, frame} !== exp4)
        $display("[TB] FAIL after_reset n=%0d: got %h, want %h", n, {an, seg, dp_n, frame}, exp4);
      else passed++;
    end
    checks++;
    if (an !== 4'hE || seg !== 7'h40)
      $display("[TB] FAIL first_digit: got an=%h seg=%h, want an=e seg=40", an, seg);
    else passed++;
  endtask

  task automatic test_scan_order();
    int frames = 0;
    int last   = -1;
    int gap    = 0;
    tick(1'b1, 16'h1234, 4'b0100, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      idle();
      checks++;
      if ({an, seg, dp_n, frame} !== exp4)
        $display("[TB] FAIL scan n=%0d: got an=%h seg=%h dp_n=%b frame=%b, want %h", n, an, seg, dp_n, frame, exp4);
      else passed++;
      if (frame === 1'b1) begin
        if (last >= 0) gap = n - last;
        last = n;
        frames++;
      end
    end
    checks++;
    if (frames != 2 || gap != 4 * DIV)
      $display("[TB] FAIL frame_period: got %0d pulses gap %0d, want 2 pulses gap %0d", frames, gap, 4 * DIV);
    else passed++;
  endtask

  task automatic test_mid_slot_load();
    for (int i = 0; i < 4 * DIV && (n % (4 * DIV)) != DIV + DEAD + 3; i++) idle();
    checks++;
    if (an !== 4'hD || seg !== 7'h30)
      $display("[TB] FAIL mid_pre: got an=%h seg=%h, want an=d seg=30", an, seg);
    else passed++;
    tick(1'b1, 16'hABCD, 4'b0000, 1'b0, 4'h0, 1'b0);
    checks++;
    if (seg !== 7'h30)
      $display("[TB] FAIL mid_load_edge: got seg=%h, want 30", seg);
    else passed++;
    idle();
    checks++;
    if (an !== 4'hD || seg !== 7'h46)
      $display("[TB] FAIL mid_new_glyph: got an=%h seg=%h, want an=d seg=46", an, seg);
    else passed++;
    for (int i = 0; i < 2 * DIV; i++) begin
      idle();
      checks++;
      if ({an, seg, dp_n, frame} !== exp4)
        $display("[TB] FAIL mid_follow n=%0d: got %h, want %h", n, {an, seg, dp_n, frame}, exp4);
      else passed++;
    end
  endtask

  task automatic test_glyph_sweep();
    for (int v = 0; v < 16; v++) begin
      int frames = 0;
      tick(1'b0, 16'h0, 4'h0, 1'b1, 4'(v), 1'($urandom_range(0, 1)));
      for (int i = 0; i < DIV; i++) begin
        idle();
        checks++;
        if ({an1, seg1, dp_n1, frame1} !== exp1)
          $display("[TB] FAIL glyph v=%h n=%0d: got %h, want %h", v, n, {an1, seg1, dp_n1, frame1}, exp1);
        else passed++;
        if (frame1 === 1'b1) frames++;
      end
      checks++;
      if (frames != 1)
        $display("[TB] FAIL frame1 v=%h: got %0d pulses, want 1", v, frames);
      else passed++;
    end
  endtask

  task automatic test_lzb();
    logic [15:0] pats [3] = '{16'h0050, 16'h0000, 16'h0000};
    logic [3:0]  dps  [3] = '{4'b0000, 4'b0000, 4'b1000};
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, pats[k], dps[k], 1'b0, 4'h0, 1'b0);
      for (int i = 0; i < 4 * DIV; i++) begin
        idle();
        checks++;
        if ({an, seg, dp_n, frame} !== exp4)
          $display("[TB] FAIL lzb k=%0d n=%0d: got an=%h seg=%h dp_n=%b, want %h", k, n, an, seg, dp_n, exp4);
        else passed++;
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 5) == 0), 16'($urandom), 4'($urandom),
           ($urandom_range(0, 5) == 0), 4'($urandom), 1'($urandom));
      checks++;
      if ({an, seg, dp_n, frame} !== exp4)
        $display("[TB] FAIL rand4 n=%0d: got %h, want %h", n, {an, seg, dp_n, frame}, exp4);
      else passed++;
      checks++;
      if ({an1, seg1, dp_n1, frame1} !== exp1)
        $display("[TB] FAIL rand1 n=%0d: got %h, want %h", n, {an1, seg1, dp_n1, frame1}, exp1);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_scan();
    for (int i = 0; i < 4 * DIV && (n % (4 * DIV)) != 2 * DIV + 5; i++) idle();
    rst = 1'b1; load = 1'b1; data = 16'hFFFF; dp = 4'hF;
    @(posedge clk); #1;
    rst = 1'b0; load = 1'b0;
    checks++;
    if ({an, seg, dp_n, frame} !== {4'hF, 7'h7F, 1'b1, 1'b0})
      $display("[TB] FAIL rst_mid: got an=%h seg=%h dp_n=%b frame=%b, want an=f seg=7f dp_n=1 frame=0",
               an, seg, dp_n, frame);
    else passed++;
    model_reset();
    for (int i = 0; i < DIV; i++) begin
      idle();
      checks++;
      if ({an, seg, dp_n, frame} !== exp4)
        $display("[TB] FAIL rst_restart n=%0d: got %h, want %h", n, {an, seg, dp_n, frame}, exp4);
      else passed++;
      if (i == DEAD) begin
        checks++;
        if (an !== 4'hE || seg !== 7'h40 || dp_n !== 1'b1)
          $display("[TB] FAIL rst_shadow: got an=%h seg=%h dp_n=%b, want an=e seg=40 dp_n=1", an, seg, dp_n);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_mid_slot_load();
    test_glyph_sweep();
    test_lzb();
    test_random();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
